stage_sequencer: RTL

Multi-cycle instruction sequencer for the CPU core. It drives the `pipeline_stage` code consumed by the signal generation unit and steps one instruction at a time through IF, ID, EX, MEM and WB. Stages an instruction does not need are skipped. MEM is held while memory or IO is not ready, bounded by a timeout. Retired instructions are counted and each retirement is reported with a one-cycle pulse.

---
 rtl/stage_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle IF/ID/EX/MEM/WB instruction sequencer with
// stage skipping, bounded MEM wait, sticky timeout flag and retire counter.
`default_nettype none

module stage_sequencer #(
   parameter int WAIT_LIMIT = 15,
   parameter int COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               halt,
   input  logic               needs_mem,
   input  logic               needs_wb,
   input  logic               is_io,
   input  logic               flush,
   input  logic               mem_ready,
   input  logic               io_ready,
   output logic [2:0]         pipeline_stage,
   output logic               instr_done,
   output logic               busy,
   output logic               timeout_err,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      ST_IF  = 3'd0,
      ST_ID  = 3'd1,
      ST_EX  = 3'd2,
      ST_MEM = 3'd3,
      ST_WB  = 3'd4
   } stage_t;

   localparam logic [7:0] C_WAIT_LAST = 8'(WAIT_LIMIT - 1);

   stage_t               r_stage;
   stage_t               w_next;
   logic                 r_mem;
   logic                 r_wb;
   logic                 r_io;
   logic [7:0]           r_wait_cnt;
   logic                 r_timeout;
   logic [COUNT_W-1:0]   r_count;
   logic                 w_ready;
   logic                 w_retire;
   logic                 w_timeout;
   logic                 w_to_mem;

   assign w_ready = r_io ? io_ready : mem_ready;

   always_comb begin
      w_next    = r_stage;
      w_retire  = 1'b0;
      w_timeout = 1'b0;
      w_to_mem  = 1'b0;
      case (r_stage)
         ST_IF: begin
            if (!halt) w_next = ST_ID;
         end
         ST_ID: begin
            w_next = ST_EX;
         end
         ST_EX: begin
            // A taken branch retires immediately, whatever the decoded flags say.
            if (flush) begin
               w_next   = ST_IF;
               w_retire = 1'b1;
            end else if (r_mem) begin
               w_next   = ST_MEM;
               w_to_mem = 1'b1;
            end else if (r_wb) begin
               w_next = ST_WB;
            end else begin
               w_next   = ST_IF;
               w_retire = 1'b1;
            end
         end
         ST_MEM: begin
            if (w_ready) begin
               if (r_wb) begin
                  w_next = ST_WB;
               end else begin
                  w_next   = ST_IF;
                  w_retire = 1'b1;
               end
            end else if (r_wait_cnt == C_WAIT_LAST) begin
               w_next    = ST_IF;
               w_timeout = 1'b1;
            end
         end
         ST_WB: begin
            w_next   = ST_IF;
            w_retire = 1'b1;
         end
         default: begin
            w_next = ST_IF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stage    <= ST_IF;
         r_mem      <= 1'b0;
         r_wb       <= 1'b0;
         r_io       <= 1'b0;
         r_wait_cnt <= 8'd0;
         r_timeout  <= 1'b0;
         r_count    <= '0;
      end else begin
         r_stage <= w_next;
         if (r_stage == ST_ID) begin
            r_mem <= needs_mem;
            r_wb  <= needs_wb;
            r_io  <= is_io;
         end
         if (w_to_mem) begin
            r_wait_cnt <= 8'd0;
         end else if (r_stage == ST_MEM && w_next == ST_MEM && r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end
         if (w_timeout) r_timeout <= 1'b1;
         if (w_retire)  r_count   <= r_count + COUNT_W'(1);
      end
   end

   assign pipeline_stage = r_stage;
   assign instr_done     = w_retire;
   assign busy           = (r_stage != ST_IF);
   assign timeout_err    = r_timeout;
   assign instr_count    = r_count;

endmodule

`default_nettype wire
